// File: rtl/trig_surf_gather.sv
// SURF trigger-word gather: phase alignment, slot compaction, cycle-aligned masking, missing-valid flags.
// Optional gated per-SURF trigger scalers when TRIG_GATHER_SCALERS_EN is defined.
module trig_surf_gather #(
    parameter  int NTIO          = 4,
    parameter  int NSURF_PER_TIO = 7,
    parameter  int SLOTS_PER_TIO = 8,
    parameter  int WORD_W        = 16,
    parameter  int CYCLE_LEN     = 8,
    parameter  int NVALID        = 2,
    parameter  int SCALER_W      = 16,
    localparam int NSURF         = NTIO * NSURF_PER_TIO,
    localparam int NSLOT         = NTIO * SLOTS_PER_TIO,
    localparam int SP            = CYCLE_LEN / NVALID,
    localparam int CW            = $clog2(CYCLE_LEN),
    localparam int SW            = (SP > 1) ? $clog2(SP) : 1,
    localparam int IW            = (NSURF > 1) ? $clog2(NSURF) : 1
) (
    input  logic                      sysclk_i,
    input  logic                      sysclk_rst_i,
    input  logic                      sysclk_phase_i,
    input  logic [NSLOT*WORD_W-1:0]   trig_dat_i,
    input  logic [NSLOT-1:0]          trig_dat_valid_i,
    input  logic [SW-1:0]             valid_offset_i,
    input  logic [NSURF-1:0]          mask_i,
    input  logic                      mask_update_i,
    input  logic                      gate_i,
    input  logic                      err_clr_i,
    input  logic [IW-1:0]             scaler_sel_i,
    output logic [NSURF*WORD_W-1:0]   trig_dat_o,
    output logic                      trig_valid_o,
    output logic                      trig_first_o,
    output logic                      locked_o,
    output logic                      phase_err_o,
    output logic [NSURF-1:0]          missing_o,
    output logic [SCALER_W-1:0]       scaler_o
);

    logic [CW-1:0]             r_ph_cnt;
    logic                      r_locked;
    logic                      r_phase_err;
    logic [NSURF-1:0]          r_mask_pend;
    logic [NSURF-1:0]          r_mask_act;
    logic [NSURF-1:0]          r_missing;
    logic [NSURF*WORD_W-1:0]   r_dat;
    logic                      r_valid;
    logic                      r_first;

    logic [WORD_W-1:0]         w_word [NSURF];
    logic [NSURF-1:0]          w_vld;
    logic [NSURF*WORD_W-1:0]   w_masked;
    logic [NSURF-1:0]          w_miss;
    logic [SW-1:0]             w_ph_mod;
    logic                      w_cap;
    logic                      w_first;

    // Spare TURFIO slots are dropped here; only the first NSURF_PER_TIO slots of each TIO survive.
    always_comb begin
        w_vld    = '0;
        w_masked = '0;
        w_miss   = '0;
        for (int t = 0; t < NTIO; t++) begin
            for (int s = 0; s < NSURF_PER_TIO; s++) begin
                w_word[t*NSURF_PER_TIO+s] = trig_dat_i[(t*SLOTS_PER_TIO+s)*WORD_W +: WORD_W];
                w_vld[t*NSURF_PER_TIO+s]  = trig_dat_valid_i[t*SLOTS_PER_TIO+s];
            end
        end
        for (int i = 0; i < NSURF; i++) begin
            w_masked[i*WORD_W +: WORD_W] = r_mask_act[i] ? '0 : w_word[i];
            w_miss[i] = !r_mask_act[i] && !w_vld[i];
        end
    end

    assign w_ph_mod = (SP > 1) ? r_ph_cnt[SW-1:0] : '0;
    assign w_cap    = r_locked && (w_ph_mod == valid_offset_i);
    assign w_first  = w_cap && (r_ph_cnt == CW'(valid_offset_i));

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            r_ph_cnt    <= '0;
            r_locked    <= 1'b0;
            r_phase_err <= 1'b0;
            r_mask_pend <= '1;
            r_mask_act  <= '1;
            r_missing   <= '0;
            r_dat       <= '0;
            r_valid     <= 1'b0;
            r_first     <= 1'b0;
        end else begin
            if (sysclk_phase_i) begin
                r_ph_cnt <= CW'(1);
                r_locked <= 1'b1;
            end else begin
                r_ph_cnt <= r_ph_cnt + CW'(1);
            end

            if (sysclk_phase_i && r_locked && (r_ph_cnt != '0))
                r_phase_err <= 1'b1;
            else if (err_clr_i)
                r_phase_err <= 1'b0;

            if (mask_update_i)
                r_mask_pend <= mask_i;
            // Active mask only moves on the cycle boundary so a cycle is never split.
            if (r_ph_cnt == '0)
                r_mask_act <= r_mask_pend;

            r_missing <= (err_clr_i ? '0 : r_missing) | (w_cap ? w_miss : '0);

            r_valid <= w_cap;
            r_first <= w_first;
            if (w_cap)
                r_dat <= w_masked;
        end
    end

    assign trig_dat_o   = r_dat;
    assign trig_valid_o = r_valid;
    assign trig_first_o = r_first;
    assign locked_o     = r_locked;
    assign phase_err_o  = r_phase_err;
    assign missing_o    = r_missing;

`ifdef TRIG_GATHER_SCALERS_EN
    logic [SCALER_W-1:0] r_acc     [NSURF];
    logic [SCALER_W-1:0] r_latched [NSURF];
    logic [SCALER_W-1:0] r_scaler;
    logic [NSURF-1:0]    w_inc;

    always_comb begin
        w_inc = '0;
        for (int i = 0; i < NSURF; i++)
            w_inc[i] = w_cap && !r_mask_act[i] && w_word[i][WORD_W-1];
    end

    // A gate coinciding with an increment starts the new period at 1.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            for (int i = 0; i < NSURF; i++) begin
                r_acc[i]     <= '0;
                r_latched[i] <= '0;
            end
            r_scaler <= '0;
        end else begin
            for (int i = 0; i < NSURF; i++) begin
                if (gate_i) begin
                    r_latched[i] <= r_acc[i];
                    r_acc[i]     <= w_inc[i] ? SCALER_W'(1) : '0;
                end else if (w_inc[i] && (r_acc[i] != '1)) begin
                    r_acc[i] <= r_acc[i] + SCALER_W'(1);
                end
            end
            r_scaler <= (int'(scaler_sel_i) < NSURF) ? r_latched[scaler_sel_i] : '0;
        end
    end

    assign scaler_o = r_scaler;
`else
    assign scaler_o = '0;
`endif

    logic w_unused;
    assign w_unused = ^{trig_dat_i, trig_dat_valid_i, gate_i, scaler_sel_i};

endmodule
